// File: rtl/user_obi_initiator.sv
// OBI manager that turns a simple valid/ready command stream into OBI A-channel requests and
// returns responses in order through a small FIFO. Caps total in-flight work at MaxOutstanding.

package obi_pkg;
  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 2};

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [1:0]  aid;
  } obi_a_chan_t;

  typedef struct packed {
    obi_a_chan_t a;
    logic        req;
    logic        rready;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  rid;
    logic        err;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;
endpackage

module user_obi_initiator #(
  parameter obi_pkg::obi_cfg_t ObiCfg         = obi_pkg::ObiDefaultConfig,
  parameter type               obi_req_t      = obi_pkg::obi_req_t,
  parameter type               obi_rsp_t      = obi_pkg::obi_rsp_t,
  parameter int unsigned       MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [3:0]  cmd_be_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  output obi_req_t    obi_req_o,
  input  obi_rsp_t    obi_rsp_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_we_o,
  output logic        rsp_err_o,
  output logic        busy_o,
  output logic        proto_err_o
);

  localparam logic [0:0]  StIdle  = 1'b0;
  localparam logic [0:0]  StReq   = 1'b1;
  localparam int unsigned IdW     = ObiCfg.IdWidth;
  localparam logic [1:0]  LastPtr = 2'(MaxOutstanding - 1);

  typedef struct packed {
    logic [31:0] rdata;
    logic        we;
    logic        err;
  } rsp_entry_t;

  logic [0:0]  state_q, state_d;
  logic        a_we_q;
  logic [3:0]  a_be_q;
  logic [31:0] a_addr_q, a_wdata_q;
  logic [1:0]  issue_cnt_q, ret_cnt_q;
  logic [2:0]  out_cnt_q, out_cnt_d;
  logic [2:0]  fifo_cnt_q, fifo_cnt_d;
  logic [1:0]  wptr_q, rptr_q;
  rsp_entry_t  fifo_q [4];
  logic [3:0]  we_tab_q;
  logic        proto_err_q, rst_q, live_out_q;

  logic          pend, gnt_fire, accept, push, pop, rv_drop, rv_stray;
  logic [3:0]    in_flight;
  logic [IdW-1:0] exp_rid;
  rsp_entry_t    push_entry;

  assign pend      = (state_q == StReq);
  assign gnt_fire  = pend & obi_rsp_i.gnt;
  assign in_flight = {3'b0, pend} + {1'b0, out_cnt_q} + {1'b0, fifo_cnt_q};

  // Held low during reset and for the first cycle after it is released.
  assign cmd_ready_o = !rst_i && !rst_q && (in_flight < 4'(MaxOutstanding)) &&
                       (!pend || obi_rsp_i.gnt);
  assign accept      = cmd_valid_i & cmd_ready_o;

  // A beat arriving right after a reset that cut off granted transactions is a late
  // response to work already discarded, so it is swallowed without flagging an error.
  assign rv_drop  = rst_q & live_out_q;
  assign push     = obi_rsp_i.rvalid & !rv_drop & (out_cnt_q != 3'd0);
  assign rv_stray = obi_rsp_i.rvalid & !rv_drop & (out_cnt_q == 3'd0);
  assign pop      = rsp_valid_o & rsp_ready_i;

  always_comb begin
    exp_rid      = '0;
    exp_rid[1:0] = ret_cnt_q;
  end

  always_comb begin
    push_entry.we    = we_tab_q[ret_cnt_q];
    push_entry.rdata = push_entry.we ? 32'h0 : obi_rsp_i.r.rdata;
    push_entry.err   = obi_rsp_i.r.err | (obi_rsp_i.r.rid != exp_rid);
  end

  always_comb begin
    state_d = state_q;
    if (accept)        state_d = StReq;
    else if (gnt_fire) state_d = StIdle;
  end

  assign out_cnt_d  = out_cnt_q + {2'b0, gnt_fire} - {2'b0, push};
  assign fifo_cnt_d = fifo_cnt_q + {2'b0, push} - {2'b0, pop};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      a_we_q      <= 1'b0;
      a_be_q      <= '0;
      a_addr_q    <= '0;
      a_wdata_q   <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      out_cnt_q   <= '0;
      fifo_cnt_q  <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      we_tab_q    <= '0;
      proto_err_q <= 1'b0;
      rst_q       <= 1'b1;
      for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
    end else begin
      rst_q      <= 1'b0;
      state_q    <= state_d;
      out_cnt_q  <= out_cnt_d;
      fifo_cnt_q <= fifo_cnt_d;
      if (accept) begin
        a_we_q    <= cmd_we_i;
        a_be_q    <= cmd_be_i;
        a_addr_q  <= cmd_addr_i;
        a_wdata_q <= cmd_wdata_i;
      end
      if (gnt_fire) begin
        we_tab_q[issue_cnt_q] <= a_we_q;
        issue_cnt_q           <= issue_cnt_q + 2'd1;
      end
      if (push) begin
        fifo_q[wptr_q] <= push_entry;
        wptr_q         <= (wptr_q == LastPtr) ? 2'd0 : wptr_q + 2'd1;
        ret_cnt_q      <= ret_cnt_q + 2'd1;
      end
      if (pop) rptr_q <= (rptr_q == LastPtr) ? 2'd0 : rptr_q + 2'd1;
      if (rv_stray) proto_err_q <= 1'b1;
    end
  end

  // Remembers across a reset whether granted work was still awaiting a response.
  always_ff @(posedge clk_i) begin
    if (!rst_i) live_out_q <= (out_cnt_d != 3'd0);
  end

  always_comb begin
    obi_req_o              = '0;
    obi_req_o.req          = pend;
    obi_req_o.rready       = 1'b1;
    obi_req_o.a.addr       = a_addr_q;
    obi_req_o.a.we         = a_we_q;
    obi_req_o.a.be         = a_be_q;
    obi_req_o.a.wdata      = a_wdata_q;
    obi_req_o.a.aid[1:0]   = issue_cnt_q;
  end

  assign rsp_valid_o = (fifo_cnt_q != 3'd0);
  assign rsp_rdata_o = fifo_q[rptr_q].rdata;
  assign rsp_we_o    = fifo_q[rptr_q].we;
  assign rsp_err_o   = fifo_q[rptr_q].err;
  assign busy_o      = (in_flight != 4'd0);
  assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_user_obi_initiator.sv
// Directed bench for user_obi_initiator: one instance at capacity 2, one at capacity 4
// (the latter for sustained back-to-back issue), sharing all stimulus.

module tb_user_obi_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_we, rsp_ready;
  logic [3:0]  cmd_be;
  logic [31:0] cmd_addr, cmd_wdata;
  obi_pkg::obi_rsp_t rsp;

  obi_pkg::obi_req_t req2, req4;
  logic        rdy2, rv2, we2, er2, busy2, perr2;
  logic [31:0] rd2;
  logic        rdy4, rv4, we4, er4, busy4, perr4;
  logic [31:0] rd4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  user_obi_initiator #(
    .ObiCfg(obi_pkg::ObiDefaultConfig), .obi_req_t(obi_pkg::obi_req_t),
    .obi_rsp_t(obi_pkg::obi_rsp_t), .MaxOutstanding(2)
  ) u2 (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(rdy2),
    .cmd_we_i(cmd_we), .cmd_be_i(cmd_be), .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .obi_req_o(req2), .obi_rsp_i(rsp), .rsp_valid_o(rv2), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rd2), .rsp_we_o(we2), .rsp_err_o(er2), .busy_o(busy2), .proto_err_o(perr2)
  );

  user_obi_initiator #(
    .ObiCfg(obi_pkg::ObiDefaultConfig), .obi_req_t(obi_pkg::obi_req_t),
    .obi_rsp_t(obi_pkg::obi_rsp_t), .MaxOutstanding(4)
  ) u4 (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(rdy4),
    .cmd_we_i(cmd_we), .cmd_be_i(cmd_be), .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .obi_req_o(req4), .obi_rsp_i(rsp), .rsp_valid_o(rv4), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rd4), .rsp_we_o(we4), .rsp_err_o(er4), .busy_o(busy4), .proto_err_o(perr4)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change before sampling.
  task automatic settle();
    #2;
  endtask

  task automatic cmd(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_be    = 4'hF;
    cmd_addr  = addr;
    cmd_wdata = wdata;
  endtask

  task automatic beat(input logic [1:0] rid, input logic [31:0] rdata, input logic err);
    rsp.rvalid  = 1'b1;
    rsp.r.rid   = rid;
    rsp.r.rdata = rdata;
    rsp.r.err   = err;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_be = 4'h0; cmd_addr = '0; cmd_wdata = '0;
    rsp = '0;
    rsp_ready = 1'b1;
    repeat (3) tick();

    // Reset state
    settle();
    check_val("rst_req", 64'(req2.req), 64'h0);
    check_val("rst_cmd_ready", 64'(rdy2), 64'h0);
    check_val("rst_rsp_valid", 64'(rv2), 64'h0);
    check_val("rst_busy", 64'(busy2), 64'h0);
    check_val("rst_proto", 64'(perr2), 64'h0);
    tick();
    rst = 1'b0;
    settle();
    check_val("ready_first_cycle", 64'(rdy2), 64'h0);
    tick();
    check_val("ready_after_rst", 64'(rdy2), 64'h1);

    // Write, gnt with req, rvalid next cycle
    cmd(1'b1, 32'h0000_0004, 32'hBEEF_0010);
    settle();
    check_val("wr_accept_ready", 64'(rdy2), 64'h1);
    tick();
    cmd_valid = 1'b0;
    rsp.gnt = 1'b1;
    settle();
    check_val("wr_req", 64'(req2.req), 64'h1);
    check_val("wr_aid", 64'(req2.a.aid), 64'h0);
    check_val("wr_addr", 64'(req2.a.addr), 64'h4);
    check_val("wr_wdata", 64'(req2.a.wdata), 64'hBEEF_0010);
    check_val("wr_we", 64'(req2.a.we), 64'h1);
    check_val("wr_be", 64'(req2.a.be), 64'hF);
    check_val("rready", 64'(req2.rready), 64'h1);
    tick();
    rsp.gnt = 1'b0;
    beat(2'd0, 32'h1234_5678, 1'b0);
    settle();
    check_val("wr_req_one_cycle", 64'(req2.req), 64'h0);
    check_val("wr_rsp_not_yet", 64'(rv2), 64'h0);
    check_val("wr_busy", 64'(busy2), 64'h1);
    tick();
    rsp.rvalid = 1'b0;
    settle();
    check_val("wr_rsp_valid", 64'(rv2), 64'h1);
    check_val("wr_rsp_we", 64'(we2), 64'h1);
    check_val("wr_rsp_rdata", 64'(rd2), 64'h0);
    check_val("wr_rsp_err", 64'(er2), 64'h0);
    tick();
    check_val("wr_drained", 64'(rv2), 64'h0);
    check_val("wr_idle_busy", 64'(busy2), 64'h0);

    // Read, gnt delayed 3 cycles
    cmd(1'b0, 32'h0000_0100, 32'h0);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) rsp.gnt = 1'b1;
      settle();
      check_val($sformatf("rd_hold_req%0d", i), 64'(req2.req), 64'h1);
      check_val($sformatf("rd_hold_addr%0d", i), 64'(req2.a.addr), 64'h100);
      check_val($sformatf("rd_hold_aid%0d", i), 64'(req2.a.aid), 64'h1);
      tick();
    end
    rsp.gnt = 1'b0;
    beat(2'd1, 32'hDEAD_BEEF, 1'b0);
    settle();
    check_val("rd_req_drop", 64'(req2.req), 64'h0);
    tick();
    rsp.rvalid = 1'b0;
    settle();
    check_val("rd_rsp_valid", 64'(rv2), 64'h1);
    check_val("rd_rsp_rdata", 64'(rd2), 64'hDEAD_BEEF);
    check_val("rd_rsp_we", 64'(we2), 64'h0);
    check_val("rd_rsp_err", 64'(er2), 64'h0);
    tick();

    // Capacity limit with responses withheld
    rsp_ready = 1'b0;
    cmd(1'b0, 32'h0000_0200, 32'h0);
    settle();
    check_val("cap_first_ready", 64'(rdy2), 64'h1);
    tick();
    rsp.gnt = 1'b1;
    cmd(1'b0, 32'h0000_0204, 32'h0);
    settle();
    check_val("cap_second_ready", 64'(rdy2), 64'h1);
    tick();
    cmd(1'b0, 32'h0000_0208, 32'h0);
    settle();
    check_val("cap_third_blocked", 64'(rdy2), 64'h0);
    tick();
    cmd_valid = 1'b0;
    rsp.gnt = 1'b0;
    settle();
    check_val("cap_two_outstanding", 64'(rdy2), 64'h0);
    beat(2'd2, 32'h0000_000A, 1'b0);
    tick();
    beat(2'd3, 32'h0000_000B, 1'b0);
    settle();
    check_val("cap_one_in_fifo", 64'(rdy2), 64'h0);
    tick();
    rsp.rvalid = 1'b0;
    settle();
    check_val("cap_fifo_full_ready", 64'(rdy2), 64'h0);
    check_val("cap_head_rdata", 64'(rd2), 64'hA);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    settle();
    check_val("cap_ready_after_pop", 64'(rdy2), 64'h1);
    check_val("cap_second_rdata", 64'(rd2), 64'hB);
    rsp_ready = 1'b1;
    tick();
    check_val("cap_drained", 64'(rv2), 64'h0);

    // Id mismatch and stray rvalid
    cmd(1'b0, 32'h0000_0300, 32'h0);
    tick();
    cmd_valid = 1'b0;
    rsp.gnt = 1'b1;
    settle();
    check_val("id_aid_wrapped", 64'(req2.a.aid), 64'h0);
    tick();
    rsp.gnt = 1'b0;
    beat(2'd1, 32'h0000_0055, 1'b0);
    tick();
    rsp.rvalid = 1'b0;
    settle();
    check_val("id_rsp_valid", 64'(rv2), 64'h1);
    check_val("id_mismatch_err", 64'(er2), 64'h1);
    tick();
    beat(2'd1, 32'h0000_0066, 1'b0);
    settle();
    check_val("stray_proto_before", 64'(perr2), 64'h0);
    tick();
    rsp.rvalid = 1'b0;
    settle();
    check_val("stray_proto_set", 64'(perr2), 64'h1);
    check_val("stray_no_push", 64'(rv2), 64'h0);
    repeat (2) tick();
    check_val("stray_proto_sticky", 64'(perr2), 64'h1);

    // Reset while waiting for gnt
    cmd(1'b0, 32'h0000_0400, 32'h0);
    tick();
    cmd_valid = 1'b0;
    settle();
    check_val("mid_req_pending", 64'(req2.req), 64'h1);
    rst = 1'b1;
    #1;
    check_val("mid_rst_req", 64'(req2.req), 64'h0);
    check_val("mid_rst_ready", 64'(rdy2), 64'h0);
    check_val("mid_rst_rsp_valid", 64'(rv2), 64'h0);
    check_val("mid_rst_rdata", 64'(rd2), 64'h0);
    check_val("mid_rst_we", 64'(we2), 64'h0);
    check_val("mid_rst_err", 64'(er2), 64'h0);
    check_val("mid_rst_busy", 64'(busy2), 64'h0);
    check_val("mid_rst_proto", 64'(perr2), 64'h0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Reset with a granted transaction outstanding; its late beat is discarded
    cmd(1'b0, 32'h0000_0500, 32'h0);
    tick();
    cmd_valid = 1'b0;
    rsp.gnt = 1'b1;
    tick();
    rsp.gnt = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    beat(2'd0, 32'h0000_0077, 1'b0);
    tick();
    rsp.rvalid = 1'b0;
    settle();
    check_val("late_beat_no_proto", 64'(perr2), 64'h0);
    check_val("late_beat_no_push", 64'(rv2), 64'h0);
    check_val("late_beat_busy", 64'(busy2), 64'h0);

    // Back-to-back reads on the capacity-4 instance
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    rsp_ready = 1'b1;
    rsp.gnt = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c < 8) cmd(1'b0, 32'(c * 4), 32'h0);
      else cmd_valid = 1'b0;
      if (c >= 2 && c < 10) beat(2'((c - 2) % 4), 32'(c - 2), 1'b0);
      else rsp.rvalid = 1'b0;
      settle();
      if (c < 8) check_val($sformatf("b2b_ready%0d", c), 64'(rdy4), 64'h1);
      if (c >= 1 && c < 9) begin
        check_val($sformatf("b2b_req%0d", c), 64'(req4.req), 64'h1);
        check_val($sformatf("b2b_aid%0d", c), 64'(req4.a.aid), 64'((c - 1) % 4));
      end
      if (c >= 3 && c < 11) begin
        check_val($sformatf("b2b_rsp_valid%0d", c), 64'(rv4), 64'h1);
        check_val($sformatf("b2b_rdata%0d", c), 64'(rd4), 64'(c - 3));
        check_val($sformatf("b2b_err%0d", c), 64'(er4), 64'h0);
      end
      tick();
    end
    rsp.gnt = 1'b0;
    settle();
    check_val("b2b_idle_busy", 64'(busy4), 64'h0);
    check_val("b2b_no_proto", 64'(perr4), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
